// File: rtl/ext_irq_ctrl.sv
// ext_irq_ctrl: PLIC-lite external interrupt controller.
// Merges NUM_SRC device lines into one registered interrupt request for the
// core. It provides per-source enable and priority, a global threshold, and a
// claim/complete handshake over a word-addressed slave port.
// Source IDs run 1..NUM_SRC; ID 0 means "no interrupt".
// Optional build macro EXT_IRQ_EDGE_EN selects rising-edge gateways.
// Without it, the gateways are level-sensitive.
module ext_irq_ctrl #(
    parameter int NUM_SRC    = 8,
    parameter int PRIO_WIDTH = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_SRC-1:0]    irq_src_i,
    input  logic                  bus_ce_i,
    input  logic                  bus_we_i,
    input  logic [ADDR_WIDTH-1:0] bus_addr_i,
    input  logic [DATA_WIDTH-1:0] bus_wdata_i,
    output logic [DATA_WIDTH-1:0] bus_rdata_o,
    output logic                  irq_external_o
);

    localparam int ID_W = $clog2(NUM_SRC + 1);

    // Word offsets within the slave window (bus_addr_i[7:2])
    localparam logic [5:0] W_PENDING   = 6'd0;
    localparam logic [5:0] W_ENABLE    = 6'd1;
    localparam logic [5:0] W_THRESHOLD = 6'd2;
    localparam logic [5:0] W_CLAIM     = 6'd3;
    localparam logic [5:0] W_PRIO_BASE = 6'd4;

    // Bit i of every per-source vector belongs to source ID i+1
    logic [NUM_SRC-1:0]    pending_q;
    logic [NUM_SRC-1:0]    in_flight_q;
    logic [NUM_SRC-1:0]    enable_q;
    logic [PRIO_WIDTH-1:0] threshold_q;
    logic [PRIO_WIDTH-1:0] prio_q [NUM_SRC];
    logic [ID_W-1:0]       best_id_q;

    logic [5:0]            word;
    logic                  rd_access;
    logic                  wr_access;
    logic                  claim;
    logic                  complete;
    logic [NUM_SRC-1:0]    claim_mask;
    logic [NUM_SRC-1:0]    complete_mask;
    logic [NUM_SRC-1:0]    set_mask;
    logic [NUM_SRC-1:0]    eligible;
    logic [ID_W-1:0]       arb_id;
    logic [PRIO_WIDTH-1:0] arb_prio;
    logic                  unused_addr;

    assign word      = bus_addr_i[7:2];
    assign rd_access = bus_ce_i & ~bus_we_i;
    assign wr_access = bus_ce_i & bus_we_i;
    assign claim     = rd_access && (word == W_CLAIM);
    assign complete  = wr_access && (word == W_CLAIM);

    assign unused_addr = ^{bus_addr_i[ADDR_WIDTH-1:8], bus_addr_i[1:0]};

    // Decode the claim target (current best_id) and a valid complete target
    always_comb begin
        claim_mask    = '0;
        complete_mask = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            claim_mask[i]    = claim && (best_id_q == ID_W'(i + 1));
            complete_mask[i] = complete && (bus_wdata_i == DATA_WIDTH'(i + 1))
                               && in_flight_q[i];
        end
    end

`ifdef EXT_IRQ_EDGE_EN
    logic [NUM_SRC-1:0] src_q;

    // Previous sample of each line for rising-edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src_q <= '0;
        end else begin
            src_q <= irq_src_i;
        end
    end

    // An edge queues one event even while the source is in flight
    assign set_mask = irq_src_i & ~src_q;
`else
    // A level-held source is blocked until its claim is completed
    assign set_mask = irq_src_i & ~in_flight_q;
`endif

    // Gateway state: claim clears pending and takes priority over a new set
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q   <= '0;
            in_flight_q <= '0;
        end else begin
            pending_q   <= (pending_q | set_mask) & ~claim_mask;
            in_flight_q <= (in_flight_q | claim_mask) & ~complete_mask;
        end
    end

    // Software-visible configuration registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            enable_q    <= '0;
            threshold_q <= '0;
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                prio_q[i] <= '0;
            end
        end else if (wr_access) begin
            if (word == W_ENABLE) begin
                enable_q <= bus_wdata_i[NUM_SRC:1];
            end
            if (word == W_THRESHOLD) begin
                threshold_q <= bus_wdata_i[PRIO_WIDTH-1:0];
            end
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (word == 6'(W_PRIO_BASE + i)) begin
                    prio_q[i] <= bus_wdata_i[PRIO_WIDTH-1:0];
                end
            end
        end
    end

    // Eligible sources: pending, enabled and above the threshold
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            eligible[i] = pending_q[i] & enable_q[i] & (prio_q[i] > threshold_q);
        end
    end

    // Highest priority wins; strict compare in ascending ID order keeps the
    // lowest ID on a tie
    always_comb begin
        arb_id   = '0;
        arb_prio = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (eligible[i] && (prio_q[i] > arb_prio)) begin
                arb_id   = ID_W'(i + 1);
                arb_prio = prio_q[i];
            end
        end
    end

    // Register arbiter result and the interrupt request together
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            best_id_q      <= '0;
            irq_external_o <= 1'b0;
        end else begin
            best_id_q      <= arb_id;
            irq_external_o <= (arb_id != '0);
        end
    end

    // Combinational read mux; unmapped words and idle cycles read zero
    always_comb begin
        bus_rdata_o = '0;
        if (rd_access) begin
            case (word)
                W_PENDING:   bus_rdata_o[NUM_SRC:1]      = pending_q;
                W_ENABLE:    bus_rdata_o[NUM_SRC:1]      = enable_q;
                W_THRESHOLD: bus_rdata_o[PRIO_WIDTH-1:0] = threshold_q;
                W_CLAIM:     bus_rdata_o[ID_W-1:0]       = best_id_q;
                default: begin
                    for (int unsigned i = 0; i < NUM_SRC; i++) begin
                        if (word == 6'(W_PRIO_BASE + i)) begin
                            bus_rdata_o[PRIO_WIDTH-1:0] = prio_q[i];
                        end
                    end
                end
            endcase
        end
    end

endmodule
